keypad_code_entry: RTL and testbench

KEYPAD_CODE_ENTRY -- requirements
Module: keypad_code_entry

---
 rtl/parking_pkg.sv | 19 +
 rtl/entry_timer.sv | 40 ++++
 rtl/keypad_code_entry.sv | 143 ++++++++++++++
 tb/tb_keypad_code_entry.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the gate keypad code-entry block.
package parking_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StSend
    } state_e;

    localparam int unsigned DIGITS                 = 4;
    localparam int unsigned DIGIT_W                = 4;
    localparam int unsigned ACK_HOLD_DEFAULT       = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] v);
        return v <= DIGIT_W'(9);
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Inactivity counter: flags expiry on the TIMEOUT_CYCLES-th consecutive enabled cycle.
module entry_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        expired = 1'b0;
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == Last) begin
                expired = 1'b1;
                count_d = '0;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/keypad_code_entry.sv
// Gate keypad PIN collector: gathers four BCD digits and hands them to the parking controller.
module keypad_code_entry
    import parking_pkg::*;
#(
    parameter int unsigned ACK_HOLD       = ACK_HOLD_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vehicle_arrival,
    input  logic                      vehicle_left,
    input  logic                      key_valid,
    input  logic [DIGIT_W-1:0]        key_value,
    input  logic                      key_clear,
    input  logic                      key_enter,
    output logic [DIGITS*DIGIT_W-1:0] code,
    output logic                      code_ack,
    output logic [2:0]                digit_count,
    output logic                      key_error,
    output logic                      entry_timeout
);

    localparam int unsigned CodeW = DIGITS * DIGIT_W;
    localparam int unsigned AckW  = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;
    localparam logic [AckW-1:0] AckLast = AckW'(ACK_HOLD - 1);
    localparam logic [2:0]      Full    = 3'(DIGITS);

    state_e           state_q, state_d;
    logic [CodeW-1:0] code_q, code_d;
    logic [2:0]       count_q, count_d;
    logic             ack_q, ack_d;
    logic [AckW-1:0]  ack_cnt_q, ack_cnt_d;
    logic             key_error_q, key_error_d;
    logic             timeout_q, timeout_d;

    logic abort;
    logic timer_clear, timer_enable, timer_expired;

    assign abort = vehicle_left | ~vehicle_arrival;

    // Leaving COLLECT always passes through a cycle outside it, which zeroes the counter.
    assign timer_clear  = (state_q != StCollect) | key_clear | key_enter | key_valid;
    assign timer_enable = (state_q == StCollect) & (count_q != 3'd0);

    entry_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_entry_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        count_d     = count_q;
        ack_d       = 1'b0;
        ack_cnt_d   = ack_cnt_q;
        key_error_d = 1'b0;
        timeout_d   = 1'b0;

        if (abort) begin
            state_d   = StIdle;
            code_d    = '0;
            count_d   = '0;
            ack_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StCollect;
                end
                StCollect: begin
                    if (key_clear) begin
                        code_d  = '0;
                        count_d = '0;
                    end else if (key_enter) begin
                        if (count_q == Full) begin
                            state_d   = StSend;
                            ack_d     = 1'b1;
                            ack_cnt_d = '0;
                        end else begin
                            key_error_d = 1'b1;
                        end
                    end else if (key_valid) begin
                        if (is_bcd(key_value) && (count_q != Full)) begin
                            code_d  = {code_q[CodeW-DIGIT_W-1:0], key_value};
                            count_d = count_q + 3'd1;
                        end else begin
                            key_error_d = 1'b1;
                        end
                    end else if (timer_expired) begin
                        code_d    = '0;
                        count_d   = '0;
                        timeout_d = 1'b1;
                    end
                end
                StSend: begin
                    if (ack_cnt_q == AckLast) begin
                        state_d   = StCollect;
                        code_d    = '0;
                        count_d   = '0;
                        ack_cnt_d = '0;
                    end else begin
                        ack_d     = 1'b1;
                        ack_cnt_d = ack_cnt_q + AckW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            code_q      <= '0;
            count_q     <= '0;
            ack_q       <= 1'b0;
            ack_cnt_q   <= '0;
            key_error_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            count_q     <= count_d;
            ack_q       <= ack_d;
            ack_cnt_q   <= ack_cnt_d;
            key_error_q <= key_error_d;
            timeout_q   <= timeout_d;
        end
    end

    assign code          = code_q;
    assign code_ack      = ack_q;
    assign digit_count   = count_q;
    assign key_error     = key_error_q;
    assign entry_timeout = timeout_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed self-checking bench for keypad_code_entry with default parameters.
module tb_keypad_code_entry;
    import parking_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        vehicle_arrival;
    logic        vehicle_left;
    logic        key_valid;
    logic [3:0]  key_value;
    logic        key_clear;
    logic        key_enter;
    logic [15:0] code;
    logic        code_ack;
    logic [2:0]  digit_count;
    logic        key_error;
    logic        entry_timeout;

    int n_cmp = 0;
    int n_err = 0;

    keypad_code_entry dut (
        .clk            (clk),
        .rst            (rst),
        .vehicle_arrival(vehicle_arrival),
        .vehicle_left   (vehicle_left),
        .key_valid      (key_valid),
        .key_value      (key_value),
        .key_clear      (key_clear),
        .key_enter      (key_enter),
        .code           (code),
        .code_ack       (code_ack),
        .digit_count    (digit_count),
        .key_error      (key_error),
        .entry_timeout  (entry_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        key_valid = 1'b1;
        key_value = v;
        tick();
        key_valid = 1'b0;
        key_value = 4'h0;
    endtask

    task automatic press_enter();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic press_clear();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
    endtask

    task automatic enter_pin(input logic [15:0] pin);
        press(pin[15:12]);
        press(pin[11:8]);
        press(pin[7:4]);
        press(pin[3:0]);
    endtask

    // Called right after press_enter(): expects four ack cycles carrying exp_code.
    task automatic check_burst(input string tag, input logic [15:0] exp_code);
        int acks;
        int bad;
        acks = 0;
        bad  = 0;
        check_eq({tag, "_ack_start"}, 32'(code_ack), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (code_ack) begin
                acks++;
                if (code !== exp_code) bad++;
            end
            tick();
        end
        check_eq({tag, "_ack_len"}, 32'(acks), 32'd4);
        check_eq({tag, "_code_held"}, 32'(bad), 32'd0);
        check_eq({tag, "_code_after"}, 32'(code), 32'h0);
        check_eq({tag, "_count_after"}, 32'(digit_count), 32'd0);
    endtask

    initial begin
        int pulses;
        int first_at;

        rst             = 1'b0;
        vehicle_arrival = 1'b0;
        vehicle_left    = 1'b0;
        key_valid       = 1'b0;
        key_value       = 4'h0;
        key_clear       = 1'b0;
        key_enter       = 1'b0;
        repeat (3) tick();

        check_eq("rst_code", 32'(code), 32'h0);
        check_eq("rst_ack", 32'(code_ack), 32'd0);
        check_eq("rst_count", 32'(digit_count), 32'd0);
        check_eq("rst_err", 32'(key_error), 32'd0);
        check_eq("rst_to", 32'(entry_timeout), 32'd0);

        rst             = 1'b1;
        vehicle_arrival = 1'b1;
        tick();

        // 5,9,9,0 then enter
        press(4'h5);
        check_eq("d1_code", 32'(code), 32'h0005);
        check_eq("d1_count", 32'(digit_count), 32'd1);
        press(4'h9);
        press(4'h9);
        press(4'h0);
        check_eq("d4_code", 32'(code), 32'h5990);
        check_eq("d4_count", 32'(digit_count), 32'd4);
        press_enter();
        check_burst("pin5990", 16'h5990);

        // Two consecutive submissions without a new arrival
        enter_pin(16'h1234);
        press_enter();
        check_burst("pin1234", 16'h1234);
        enter_pin(16'h3145);
        press_enter();
        check_burst("pin3145", 16'h3145);

        // Illegal key and short enter
        press(4'h1);
        press(4'h2);
        press(4'hA);
        check_eq("bad_key_err", 32'(key_error), 32'd1);
        check_eq("bad_key_count", 32'(digit_count), 32'd2);
        tick();
        check_eq("bad_key_pulse", 32'(key_error), 32'd0);
        press_enter();
        check_eq("short_enter_err", 32'(key_error), 32'd1);
        check_eq("short_enter_ack", 32'(code_ack), 32'd0);
        check_eq("short_enter_count", 32'(digit_count), 32'd2);
        check_eq("short_enter_code", 32'(code), 32'h0012);
        press_clear();
        check_eq("clear_count", 32'(digit_count), 32'd0);
        check_eq("clear_code", 32'(code), 32'h0);

        // Fifth digit rejected
        enter_pin(16'h4321);
        press(4'h7);
        check_eq("fifth_err", 32'(key_error), 32'd1);
        check_eq("fifth_code", 32'(code), 32'h4321);
        check_eq("fifth_count", 32'(digit_count), 32'd4);

        // Simultaneous strobes: clear wins silently
        key_clear = 1'b1;
        key_enter = 1'b1;
        key_valid = 1'b1;
        key_value = 4'h5;
        tick();
        key_clear = 1'b0;
        key_enter = 1'b0;
        key_valid = 1'b0;
        key_value = 4'h0;
        check_eq("prio_count", 32'(digit_count), 32'd0);
        check_eq("prio_err", 32'(key_error), 32'd0);
        tick();
        check_eq("prio_ack", 32'(code_ack), 32'd0);

        // Timeout after 1000 idle cycles
        press(4'h1);
        press(4'h2);
        pulses   = 0;
        first_at = 0;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (entry_timeout) begin
                pulses++;
                if (first_at == 0) first_at = i;
                check_eq("to_no_err", 32'(key_error), 32'd0);
            end
        end
        check_eq("to_pulses", 32'(pulses), 32'd1);
        check_eq("to_cycle", 32'(first_at), 32'd1000);
        check_eq("to_code", 32'(code), 32'h0);
        check_eq("to_count", 32'(digit_count), 32'd0);

        // vehicle_left during the second ack cycle
        enter_pin(16'h1234);
        press_enter();
        tick();
        check_eq("abort_ack2", 32'(code_ack), 32'd1);
        vehicle_left = 1'b1;
        tick();
        check_eq("abort_ack", 32'(code_ack), 32'd0);
        check_eq("abort_code", 32'(code), 32'h0);
        check_eq("abort_count", 32'(digit_count), 32'd0);
        check_eq("abort_state", 32'(dut.state_q), 32'(StIdle));
        press(4'h5);
        check_eq("idle_key_count", 32'(digit_count), 32'd0);
        check_eq("idle_key_err", 32'(key_error), 32'd0);
        vehicle_left = 1'b0;
        tick();

        // Reset during the second ack cycle
        enter_pin(16'h8765);
        press_enter();
        tick();
        check_eq("rst_mid_ack2", 32'(code_ack), 32'd1);
        rst = 1'b0;
        tick();
        check_eq("rst_mid_code", 32'(code), 32'h0);
        check_eq("rst_mid_ack", 32'(code_ack), 32'd0);
        check_eq("rst_mid_count", 32'(digit_count), 32'd0);
        check_eq("rst_mid_err", 32'(key_error), 32'd0);
        check_eq("rst_mid_to", 32'(entry_timeout), 32'd0);
        check_eq("rst_mid_state", 32'(dut.state_q), 32'(StIdle));
        rst = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
